// File: rtl/alu_arbiter_if.sv
// Request/response bus between the two requesters and the ALU arbiter.
// Port p uses req_valid[p]/req_ready[p] and req_*p; responses share one data path.
interface alu_arbiter_if #(
   parameter int DW  = 4,
   parameter int OPW = 3
);
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [DW-1:0]  req_a0;
   logic [DW-1:0]  req_b0;
   logic [DW-1:0]  req_a1;
   logic [DW-1:0]  req_b1;
   logic [OPW-1:0] req_op0;
   logic [OPW-1:0] req_op1;
   logic [1:0]     rsp_valid;
   logic [DW-1:0]  rsp_result;
   logic           rsp_carry;
   logic           rsp_zero;

   modport master (
      output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
      input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
      output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one registered ALU; tracks each
// accepted operation through the ALU stage and routes its result back.
module alu_arbiter #(
   parameter int DW   = 4,
   parameter int OPW  = 3,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   alu_arbiter_if.slave    bus,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [OPW-1:0]  alu_op,
   input  logic [DW-1:0]   alu_result,
   input  logic            alu_carry,
   input  logic            alu_zero,
   output logic [CNTW-1:0] done_cnt0,
   output logic [CNTW-1:0] done_cnt1,
   output logic            busy
);

   logic [1:0] grant;
   logic       accept;
   logic       grant_id;
   logic       last_grant;
   logic       v1, id1;
   logic       v2, id2;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      grant = 2'b00;
      if (en) begin
         unique case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // A grant is only ever given to a valid port, so any grant is an accept.
   assign bus.req_ready = grant;
   assign accept        = |grant;
   assign grant_id      = grant[1];
   assign busy          = v1 | v2;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= '0;
         last_grant <= 1'b1;
         v1         <= 1'b0;
         id1        <= 1'b0;
         v2         <= 1'b0;
         id2        <= 1'b0;
      end else begin
         v1  <= accept;
         v2  <= v1;
         id2 <= id1;
         if (accept) begin
            id1        <= grant_id;
            last_grant <= grant_id;
            alu_a      <= grant_id ? bus.req_a1  : bus.req_a0;
            alu_b      <= grant_id ? bus.req_b1  : bus.req_b0;
            alu_op     <= grant_id ? bus.req_op1 : bus.req_op0;
         end
      end
   end

   // Stage-2 tag lines up with the ALU's registered result for the same operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid  <= 2'b00;
         bus.rsp_result <= '0;
         bus.rsp_carry  <= 1'b0;
         bus.rsp_zero   <= 1'b0;
         done_cnt0      <= '0;
         done_cnt1      <= '0;
      end else begin
         bus.rsp_valid <= 2'b00;
         if (v2) begin
            bus.rsp_valid  <= id2 ? 2'b10 : 2'b01;
            bus.rsp_result <= alu_result;
            bus.rsp_carry  <= alu_carry;
            bus.rsp_zero   <= alu_zero;
            if (id2) done_cnt1 <= done_cnt1 + CNTW'(1);
            else     done_cnt0 <= done_cnt0 + CNTW'(1);
         end
      end
   end

endmodule
